// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Stream format is LEN, 4*N little-endian data bytes and, when IMEM_LOADER_CSUM_EN
// is defined, a trailing checksum byte. The CPU is held in reset until DONE.
module imem_loader #(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned WORD_W     = 32
) (
   input  logic                  clk,
   input  logic                  rstd,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  wr_en,
   output logic [DEPTH_LOG2-1:0] wr_addr,
   output logic [WORD_W-1:0]     wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err,
   output logic [DEPTH_LOG2:0]   word_cnt
);

   localparam int unsigned CntW = DEPTH_LOG2 + 1;
   // LEN byte of 0 selects a full memory image
   localparam logic [CntW-1:0] FullCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef IMEM_LOADER_CSUM_EN
   typedef enum logic [2:0] {
      StIdle = 3'd0, StLen = 3'd1, StData = 3'd2, StCsum = 3'd3, StDone = 3'd4, StErr = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle = 3'd0, StLen = 3'd1, StData = 3'd2, StDone = 3'd4
   } state_e;
`endif

   state_e            state_q, state_d;
   logic [CntW-1:0]   target_q;
   logic [CntW-1:0]   word_cnt_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       buf_q;
   logic              wr_en_q;
   logic [DEPTH_LOG2-1:0] wr_addr_q;
   logic [WORD_W-1:0] wr_data_q;
   logic              accept;
   logic              restart;
   logic              last_byte;
   logic              last_word;

`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0] sum_q;
   logic [7:0] sum_nxt;
   assign sum_nxt = sum_q + in_data;
   assign restart = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
`else
   assign restart = start && (state_q == StIdle || state_q == StDone);
`endif

   // Ready is a pure decode of the registered state
`ifdef IMEM_LOADER_CSUM_EN
   assign in_ready  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
`else
   assign in_ready  = (state_q == StLen) || (state_q == StData);
`endif
   assign accept    = in_valid && in_ready;
   assign last_byte = (byte_idx_q == 2'd3);
   assign last_word = ((word_cnt_q + 1'b1) == target_q);

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign word_cnt = word_cnt_q;

   // State register
   always_ff @(posedge clk) begin
      if (rstd) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Next-state and status decode
   always_comb begin
      state_d  = state_q;
      cpu_hold = (state_q != StDone);
      done     = (state_q == StDone);
`ifdef IMEM_LOADER_CSUM_EN
      err      = (state_q == StErr);
`else
      err      = 1'b0;
`endif
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StLen;
`ifdef IMEM_LOADER_CSUM_EN
         StErr:          if (start) state_d = StLen;
`endif
         StLen:          if (accept) state_d = StData;
         StData: begin
            if (accept && last_byte && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
               state_d = StCsum;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         StCsum:         if (accept) state_d = (sum_nxt == 8'd0) ? StDone : StErr;
`endif
         default:        state_d = StIdle;
      endcase
   end

   // Word assembly, write port and counters
   always_ff @(posedge clk) begin
      if (rstd) begin
         target_q   <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         buf_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         if (restart) begin
            word_cnt_q <= '0;
            byte_idx_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q      <= '0;
`endif
         end
         if (state_q == StLen && accept) begin
            target_q <= (in_data == 8'd0) ? FullCnt : CntW'(in_data);
         end
         if (state_q == StData && accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q      <= sum_nxt;
`endif
            if (last_byte) begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= word_cnt_q[DEPTH_LOG2-1:0];
               wr_data_q  <= WORD_W'({in_data, buf_q});
               word_cnt_q <= word_cnt_q + 1'b1;
            end else begin
               buf_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CSUM_EN if defined.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstd;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [8:0]  word_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wr_n     = 0;
   logic [7:0]  log_addr [0:1023];
   logic [31:0] log_data [0:1023];
   int          log_cyc  [0:1023];

   imem_loader #(.DEPTH_LOG2(8), .WORD_W(32)) dut (
      .clk      (clk),
      .rstd     (rstd),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every write strobe seen mid-cycle
   always @(negedge clk) begin
      if (wr_en === 1'b1 && wr_n < 1024) begin
         log_addr[wr_n] = wr_addr;
         log_data[wr_n] = wr_data;
         log_cyc[wr_n]  = cyc;
         wr_n++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      #1;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic csum(input logic [7:0] c);
`ifdef IMEM_LOADER_CSUM_EN
      send(c);
`else
      if (c === 8'hxx) $display("unused");
`endif
   endtask

   initial begin
      int base;
      int c12;
      int bad;
      rstd     = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      rstd = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_no_writes", wr_n, 0);

      // Single-word load at full rate
      pulse_start();
      chk("start_ready", in_ready, 1);
      base = wr_n;
      send(8'h01); send(8'h78); send(8'h56); send(8'h34);
      send(8'h12);
      c12 = cyc;
      csum(8'hEC);
      idle();
      chk("w1_count", wr_n - base, 1);
      chk("w1_addr", log_addr[base], 0);
      chk("w1_data", log_data[base], 32'h12345678);
      chk("w1_latency", log_cyc[base], c12 + 1);
      chk("w1_done", done, 1);
      chk("w1_cpu_hold", cpu_hold, 0);
      chk("w1_err", err, 0);
      chk("w1_word_cnt", word_cnt, 1);
      chk("w1_in_ready", in_ready, 0);

`ifdef IMEM_LOADER_CSUM_EN
      // Bad checksum
      pulse_start();
      chk("restart_done_clr", done, 0);
      base = wr_n;
      send(8'h01); send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'hED);
      idle();
      chk("bad_err", err, 1);
      chk("bad_done", done, 0);
      chk("bad_cpu_hold", cpu_hold, 1);
      chk("bad_count", wr_n - base, 1);
      chk("bad_data", log_data[base], 32'h12345678);
`endif

      // Restart clears status
      pulse_start();
      chk("clr_done", done, 0);
      chk("clr_err", err, 0);
      chk("clr_cpu_hold", cpu_hold, 1);
      chk("clr_word_cnt", word_cnt, 0);
      chk("clr_in_ready", in_ready, 1);

      // Full-depth load, byte i = i mod 256; bytes sum to 0 mod 256 so C = 0
      base = wr_n;
      send(8'h00);
      for (int i = 0; i < 1024; i++) send(8'(i));
      csum(8'h00);
      idle();
      chk("full_count", wr_n - base, 256);
      bad = 0;
      for (int i = 0; i < 256; i++) if (log_addr[base + i] !== 8'(i)) bad++;
      chk("full_addr_order", bad, 0);
      chk("full_first_data", log_data[base], 32'h03020100);
      chk("full_last_data", log_data[base + 255], 32'hFFFEFDFC);
      chk("full_spacing", log_cyc[base + 255] - log_cyc[base], 1020);
      chk("full_word_cnt", word_cnt, 256);
      chk("full_done", done, 1);

      // Gapped two-word load with an ignored start pulse mid-load
      pulse_start();
      base = wr_n;
      send(8'h02); send(8'h44); idle(); idle(); send(8'h33); send(8'h22); idle();
      send(8'h11);
      pulse_start();
      chk("gap_ignored_start_cnt", word_cnt, 1);
      chk("gap_ignored_start_rdy", in_ready, 1);
      send(8'h88); idle(); send(8'h77); send(8'h66); send(8'h55); idle(); idle();
      csum(8'h9C);
      idle();
      chk("gap_count", wr_n - base, 2);
      chk("gap_addr0", log_addr[base], 0);
      chk("gap_data0", log_data[base], 32'h11223344);
      chk("gap_addr1", log_addr[base + 1], 1);
      chk("gap_data1", log_data[base + 1], 32'h55667788);
      chk("gap_done", done, 1);
      chk("gap_word_cnt", word_cnt, 2);

      // Reset mid-load, then a fresh one-word load
      pulse_start();
      base = wr_n;
      send(8'h04);
      for (int i = 0; i < 8; i++) send(8'(i + 1));
      idle();
      chk("abort_pre_count", wr_n - base, 2);
      @(negedge clk);
      rstd = 1'b1;
      #1;
      @(negedge clk);
      rstd = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_cpu_hold", cpu_hold, 1);
      chk("abort_word_cnt", word_cnt, 0);
      chk("abort_done", done, 0);
      pulse_start();
      base = wr_n;
      send(8'h01); send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
      csum(8'hF2);
      idle();
      chk("fresh_count", wr_n - base, 1);
      chk("fresh_addr", log_addr[base], 0);
      chk("fresh_data", log_data[base], 32'hAABBCCDD);
      chk("fresh_word_cnt", word_cnt, 1);
      chk("fresh_done", done, 1);
      chk("fresh_cpu_hold", cpu_hold, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives the instruction memory's write port. It holds the CPU in reset until a complete, verified image has been written. It is the writer side of the instruction path; the CPU fetch stage is the reader and indexes the memory with pc[7:0].

## Interface
- DEPTH_LOG2, 8, instruction memory address width (memory depth is 2**DEPTH_LOG2 words)
- WORD_W, 32, instruction word width; must be 32

- clk  in  1  clock; all logic is on the rising edge
- rstd  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  byte available on in_data
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high on a clk edge
- in_data  in  8  stream byte
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  DEPTH_LOG2  word address
- wr_data  out  WORD_W  word to write
- cpu_hold  out  1  drives the CPU's reset; high holds the CPU in reset
- done  out  1  image loaded successfully; level
- err  out  1  checksum failure; level
- word_cnt  out  DEPTH_LOG2+1  words written in the current load

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE --start--> LEN. DONE or ERR --start--> LEN; this clears done, err and word_cnt and raises cpu_hold. A start pulse in LEN, DATA or CSUM is ignored.
- LEN: one accepted byte sets the target word count N. A value of 0 means 2**DEPTH_LOG2. Next state is DATA.
- DATA:
  - Bytes are packed little-endian: byte k of each word goes to bits [8k+7:8k].
  - When the 4th byte of a word is accepted, the word is committed and word_cnt increments.
  - After the Nth word, the next state is CSUM, or DONE if the checksum is compiled out.
- CSUM: one accepted byte C. If (sum of all DATA bytes + C) mod 256 == 0, next state is DONE; otherwise ERR. The LEN byte is not included in the sum.
- DONE: cpu_hold=0, done=1.
- ERR: cpu_hold=1, err=1. Memory contents are left as written.
- in_ready=1 exactly in LEN, DATA and CSUM; it is a decode of the registered state only. The loader never back-pressures inside a state.
- wr_addr equals the zero-based word index. It never wraps, because N ≤ depth.
- The byte running sum is 8-bit modular. The byte index is 2 bits.

## Timing
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0, word_cnt=0. Reset applied mid-load aborts the load immediately and the CPU stays held.
- Write latency: wr_en is high for exactly one cycle, the cycle after the edge that accepted the word's 4th byte. wr_addr and wr_data are valid in that same cycle.
- A new byte may be accepted in the same cycle wr_en is high. Back-to-back words produce wr_en pulses 4 cycles apart at full rate.
- The last DATA word's wr_en occurs in the first CSUM cycle (or first DONE cycle if the checksum is compiled out).
- cpu_hold falls on the same edge that enters DONE. done and err change on the same edges as the state.
- in_valid low in any state: the loader holds state with no side effects. There is no timeout.

## Configuration
- IMEM_LOADER_CSUM_EN defined:
  - CSUM state and running sum are present.
  - The stream is LEN, 4N data bytes, then C.
  - err can assert.
- IMEM_LOADER_CSUM_EN undefined:
  - No CSUM state and no sum register.
  - DATA goes directly to DONE after the Nth word.
  - The stream is LEN then 4N bytes.
  - err is tied to 0.

## Test plan
- Reset then idle 10 cycles -> cpu_hold=1, in_ready=0, done=0, err=0, no wr_en.
- start; stream 01,78,56,34,12,EC at full rate (CSUM_EN) -> one wr_en with wr_addr=0, wr_data=0x12345678, one cycle after byte 0x12; then done=1, cpu_hold=0, word_cnt=1.
- Same stream with final byte 0xED -> err=1, done=0, cpu_hold=1, memory word 0 still written.
- LEN=00 followed by 1024 bytes (byte i = i mod 256) and a correct C -> 256 wr_en pulses, addresses 0..255 in order, last wr_data=0xFFFEFDFC, word_cnt=256, done=1.
- Randomly deassert in_valid during DATA, and pulse start mid-load -> identical memory writes and completion as the gap-free run; start has no effect.
- Assert rstd after 2 words of a 4-word load, then start a fresh 1-word load -> the fresh word lands at wr_addr=0, word_cnt=1, done=1.
